// File: rtl/hazard_ctrl.sv
// D-stage hazard controller: keeps a shadow pipeline of {A3, T_new} per post-D stage
// plus a mult/div busy counter, and from them produces the stall and forwarding selects.
module hazard_ctrl #(
  parameter  int STAGES  = 3,
  parameter  int MUL_CYC = 5,
  parameter  int DIV_CYC = 10,
  localparam int SW      = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  input  logic [1:0]    d_tuse_rs,
  input  logic [1:0]    d_tuse_rt,
  input  logic [1:0]    d_tnew,
  input  logic [4:0]    d_a3,
  input  logic          d_md,
  input  logic          d_is_div,
  input  logic          d_mfmt,
  output logic          stall,
  output logic [SW-1:0] fwd_rs_sel,
  output logic [SW-1:0] fwd_rt_sel,
  output logic          mdu_start,
  output logic          mdu_busy
);

  localparam int MAXC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  logic [4:0]        a3_q   [STAGES];
  logic [4:0]        a3_d   [STAGES];
  logic [1:0]        tnew_q [STAGES];
  logic [1:0]        tnew_d [STAGES];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              start_q, start_d;

  logic [STAGES-1:0] match_rs, match_rt, haz_rs, haz_rt;
  logic              mdu_haz, issue;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    // Register 0 is never a real destination, so it can never match.
    assign match_rs[gi] = (a3_q[gi] != 5'd0) && (a3_q[gi] == d_rs);
    assign match_rt[gi] = (a3_q[gi] != 5'd0) && (a3_q[gi] == d_rt);
    assign haz_rs[gi]   = match_rs[gi] && (tnew_q[gi] > d_tuse_rs);
    assign haz_rt[gi]   = match_rt[gi] && (tnew_q[gi] > d_tuse_rt);

    if (gi == 0) begin : g_head
      assign a3_d[gi]   = issue ? d_a3   : 5'd0;
      assign tnew_d[gi] = issue ? d_tnew : 2'd0;
    end else begin : g_tail
      assign a3_d[gi]   = a3_q[gi-1];
      assign tnew_d[gi] = (tnew_q[gi-1] == 2'd0) ? 2'd0 : tnew_q[gi-1] - 2'd1;
    end
  end

  // Scan oldest to youngest so the youngest match wins; a young, unfinished
  // producer therefore shadows any older ready one and yields 0.
  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (match_rs[i]) fwd_rs_sel = (tnew_q[i] == 2'd0) ? SW'(i + 1) : '0;
      if (match_rt[i]) fwd_rt_sel = (tnew_q[i] == 2'd0) ? SW'(i + 1) : '0;
    end
  end

  assign mdu_busy  = (cnt_q != '0);
  assign mdu_start = start_q;
  assign mdu_haz   = d_valid && (d_md || d_mfmt) && (mdu_busy || start_q);
  assign stall     = (d_valid && ((|haz_rs) || (|haz_rt))) || mdu_haz;
  assign issue     = d_valid && !stall;

  always_comb begin
    start_d = issue && d_md;
    cnt_d   = cnt_q;
    if (issue && d_md) begin
      cnt_d = d_is_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        a3_q[i]   <= 5'd0;
        tnew_q[i] <= 2'd0;
      end
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        a3_q[i]   <= a3_d[i];
        tnew_q[i] <= tnew_d[i];
      end
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a default instance (A) and a STAGES=4/MUL_CYC=3 instance (B)
// share D-stage inputs; a timestamp-based issue-history model predicts both.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       d_valid, d_md, d_is_div, d_mfmt;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;

  logic       stall_a, start_a, busy_a, stall_b, start_b, busy_b;
  logic [1:0] rs_a, rt_a;
  logic [2:0] rs_b, rt_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: per-cycle issue history (ring buffer) and last MDU start time.
  int  ns[2]   = '{3, 4};
  int  mulc[2] = '{5, 3};
  bit  h_iss[2][16];
  int  h_a3[2][16];
  int  h_tn[2][16];
  int  lmc[2];
  int  llen[2];
  bit  e_stall[2], e_start[2], e_busy[2];
  int  e_rs[2], e_rt[2];

  always #5 clk = ~clk;

  hazard_ctrl u_a (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_tnew(d_tnew), .d_a3(d_a3),
    .d_md(d_md), .d_is_div(d_is_div), .d_mfmt(d_mfmt), .stall(stall_a),
    .fwd_rs_sel(rs_a), .fwd_rt_sel(rt_a), .mdu_start(start_a), .mdu_busy(busy_a)
  );

  hazard_ctrl #(.STAGES(4), .MUL_CYC(3), .DIV_CYC(10)) u_b (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_tnew(d_tnew), .d_a3(d_a3),
    .d_md(d_md), .d_is_div(d_is_div), .d_mfmt(d_mfmt), .stall(stall_b),
    .fwd_rs_sel(rs_b), .fwd_rt_sel(rt_b), .mdu_start(start_b), .mdu_busy(busy_b)
  );

  function automatic logic act_stall(input int n); return (n == 0) ? stall_a : stall_b; endfunction
  function automatic logic act_start(input int n); return (n == 0) ? start_a : start_b; endfunction
  function automatic logic act_busy(input int n);  return (n == 0) ? busy_a  : busy_b;  endfunction
  function automatic int act_rs(input int n); return (n == 0) ? int'(rs_a) : int'(rs_b); endfunction
  function automatic int act_rt(input int n); return (n == 0) ? int'(rt_a) : int'(rt_b); endfunction

  function automatic void model_clear();
    for (int n = 0; n < 2; n++) begin
      for (int s = 0; s < 16; s++) begin
        h_iss[n][s] = 1'b0;
        h_a3[n][s]  = 0;
        h_tn[n][s]  = 0;
      end
      lmc[n]  = -1000;
      llen[n] = 0;
    end
  endfunction

  // An instruction issued c cycles ago (c = 1 is E) has T_new reduced by c-1.
  function automatic void src_eval(input int n, input int r, input int tuse,
                                   output int sel, output bit haz);
    bit found = 1'b0;
    sel = 0;
    haz = 1'b0;
    for (int i = 0; i < ns[n]; i++) begin
      int c = cyc - 1 - i;
      int slot, rem;
      if (c < 0) continue;
      slot = c % 16;
      if (h_iss[n][slot] && h_a3[n][slot] != 0 && h_a3[n][slot] == r) begin
        rem = h_tn[n][slot] - i;
        if (rem < 0) rem = 0;
        if (rem > tuse) haz = 1'b1;
        if (!found) begin
          found = 1'b1;
          sel = (rem == 0) ? i + 1 : 0;
        end
      end
    end
  endfunction

  task automatic drive(input bit v, input int rs, input int rt, input int tur, input int tut,
                       input int tn, input int a3, input bit md, input bit dv, input bit mf);
    d_valid = v;       d_rs = 5'(rs);        d_rt = 5'(rt);
    d_tuse_rs = 2'(tur); d_tuse_rt = 2'(tut); d_tnew = 2'(tn);
    d_a3 = 5'(a3);     d_md = md;            d_is_div = dv;  d_mfmt = mf;
  endtask

  task automatic eval();
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      int srs, srt;
      bit hrs, hrt, busy;
      src_eval(n, int'(d_rs), int'(d_tuse_rs), srs, hrs);
      src_eval(n, int'(d_rt), int'(d_tuse_rt), srt, hrt);
      busy       = (cyc > lmc[n]) && (cyc <= lmc[n] + llen[n]);
      e_busy[n]  = busy;
      e_start[n] = (cyc == lmc[n] + 1);
      e_rs[n]    = srs;
      e_rt[n]    = srt;
      e_stall[n] = d_valid && (hrs || hrt || ((d_md || d_mfmt) && busy));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      int slot = cyc % 16;
      h_iss[n][slot] = reset && d_valid && !e_stall[n];
      h_a3[n][slot]  = int'(d_a3);
      h_tn[n][slot]  = int'(d_tnew);
      if (h_iss[n][slot] && d_md) begin
        lmc[n]  = cyc;
        llen[n] = d_is_div ? 10 : mulc[n];
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int k);
    drive(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
    repeat (k) begin eval(); advance(); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    repeat (3) begin
      drive(1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31),
            1'($urandom), 1'($urandom), 1'($urandom));
      eval();
      for (int n = 0; n < 2; n++) begin
        checks += 4;
        if (act_stall(n) !== 1'b0) begin errors++; $display("FAIL reset_stall inst%0d: got %0b want 0", n, act_stall(n)); end
        if (act_busy(n) !== 1'b0 || act_start(n) !== 1'b0) begin
          errors++; $display("FAIL reset_mdu inst%0d: busy %0b start %0b want 0 0", n, act_busy(n), act_start(n));
        end
        if (act_rs(n) !== 0) begin errors++; $display("FAIL reset_fwd_rs inst%0d: got %0d want 0", n, act_rs(n)); end
        if (act_rt(n) !== 0) begin errors++; $display("FAIL reset_fwd_rt inst%0d: got %0d want 0", n, act_rt(n)); end
      end
      advance();
    end
    reset = 1'b1;
    drive(1, 8, 9, 0, 0, 2, 8, 0, 0, 0);
    eval();
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (act_stall(n) !== 1'b0) begin errors++; $display("FAIL first_issue inst%0d: stall %0b want 0", n, act_stall(n)); end
    end
    advance();
    $display("test_reset done");
  endtask

  // Producer then back-to-back consumer on rs; counts stall cycles per instance.
  task automatic test_load_use();
    int tn_t[3]  = '{2, 2, 3};
    int tu_t[3]  = '{1, 0, 0};
    int stl_t[3] = '{1, 2, 3};
    for (int t = 0; t < 3; t++) begin
      int st[2], sel[2], msel[2];
      bit done[2];
      idle(5);
      drive(1, 0, 0, 3, 3, tn_t[t], 8, 0, 0, 0);
      eval(); advance();
      drive(1, 8, 0, tu_t[t], 3, 1, 10, 0, 0, 0);
      st = '{0, 0}; done = '{0, 0}; sel = '{0, 0}; msel = '{0, 0};
      for (int k = 0; k < 12 && !(done[0] && done[1]); k++) begin
        eval();
        for (int n = 0; n < 2; n++) begin
          if (!done[n]) begin
            if (act_stall(n) === 1'b1) st[n]++;
            else begin done[n] = 1'b1; sel[n] = act_rs(n); msel[n] = e_rs[n]; end
          end
        end
        advance();
      end
      for (int n = 0; n < 2; n++) begin
        int want_sel = msel[n];
        if (tu_t[t] == 0 && tn_t[t] == 2) want_sel = 3;
        if (tn_t[t] == 3) want_sel = (n == 1) ? 4 : 0;
        checks += 2;
        if (!done[n] || st[n] != stl_t[t]) begin
          errors++; $display("FAIL load_use_stalls case%0d inst%0d: got %0d want %0d", t, n, st[n], stl_t[t]);
        end
        if (sel[n] != want_sel) begin
          errors++; $display("FAIL load_use_fwd case%0d inst%0d: got %0d want %0d", t, n, sel[n], want_sel);
        end
      end
      $display("test_load_use case %0d tnew=%0d tuse=%0d stalls=%0d/%0d", t, tn_t[t], tu_t[t], st[0], st[1]);
    end
  endtask

  task automatic test_alu_chain();
    idle(5);
    drive(1, 0, 0, 3, 3, 1, 9, 0, 0, 0);
    eval(); advance();
    drive(1, 9, 9, 1, 1, 1, 11, 0, 0, 0);
    eval();
    for (int n = 0; n < 2; n++) begin
      checks += 3;
      if (act_stall(n) !== 1'b0) begin errors++; $display("FAIL alu_stall inst%0d: got %0b want 0", n, act_stall(n)); end
      if (act_rs(n) !== e_rs[n]) begin errors++; $display("FAIL alu_fwd_rs inst%0d: got %0d want %0d", n, act_rs(n), e_rs[n]); end
      if (act_rt(n) !== e_rt[n]) begin errors++; $display("FAIL alu_fwd_rt inst%0d: got %0d want %0d", n, act_rt(n), e_rt[n]); end
    end
    advance();
    idle(5);
    drive(1, 0, 0, 3, 3, 1, 0, 0, 0, 0);
    eval(); advance();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    eval();
    for (int n = 0; n < 2; n++) begin
      checks += 2;
      if (act_stall(n) !== 1'b0) begin errors++; $display("FAIL a3zero_stall inst%0d: got %0b want 0", n, act_stall(n)); end
      if (act_rs(n) !== 0 || act_rt(n) !== 0) begin
        errors++; $display("FAIL a3zero_fwd inst%0d: rs %0d rt %0d want 0 0", n, act_rs(n), act_rt(n));
      end
    end
    advance();
    $display("test_alu_chain done");
  endtask

  // md start, one unrelated addu, then mfhi until both instances issue it.
  task automatic test_mdu(input bit is_div);
    int bsy[2], sts[2], stl[2];
    bit done[2];
    idle(12);
    drive(1, 0, 0, 3, 3, 0, 0, 1, is_div, 0);
    eval(); advance();
    drive(1, 0, 0, 3, 3, 1, 12, 0, 0, 0);
    eval();
    bsy = '{0, 0}; sts = '{0, 0}; stl = '{0, 0}; done = '{0, 0};
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (act_stall(n) !== 1'b0) begin errors++; $display("FAIL mdu_addu_stall inst%0d: got %0b want 0", n, act_stall(n)); end
      if (act_busy(n) === 1'b1) bsy[n]++;
      if (act_start(n) === 1'b1) sts[n]++;
    end
    advance();
    drive(1, 0, 0, 3, 3, 1, 0, 0, 0, 1);
    for (int k = 0; k < 20 && !(done[0] && done[1]); k++) begin
      eval();
      for (int n = 0; n < 2; n++) begin
        if (!done[n]) begin
          if (act_busy(n) === 1'b1) bsy[n]++;
          if (act_start(n) === 1'b1) sts[n]++;
          if (act_stall(n) === 1'b1) stl[n]++; else done[n] = 1'b1;
        end
      end
      advance();
    end
    for (int n = 0; n < 2; n++) begin
      int len = is_div ? 10 : mulc[n];
      checks += 3;
      if (sts[n] != 1) begin errors++; $display("FAIL mdu_start_pulses inst%0d: got %0d want 1", n, sts[n]); end
      if (bsy[n] != len) begin errors++; $display("FAIL mdu_busy_cycles inst%0d: got %0d want %0d", n, bsy[n], len); end
      if (!done[n] || stl[n] != len - 1) begin
        errors++; $display("FAIL mdu_mf_stalls inst%0d: got %0d want %0d", n, stl[n], len - 1);
      end
    end
    $display("test_mdu div=%0b busy=%0d/%0d mf_stalls=%0d/%0d", is_div, bsy[0], bsy[1], stl[0], stl[1]);
  endtask

  task automatic test_reset_mid_div();
    idle(12);
    drive(1, 0, 0, 3, 3, 0, 0, 1, 1, 0);
    eval(); advance();
    drive(1, 0, 0, 3, 3, 1, 0, 0, 0, 1);
    repeat (6) begin eval(); advance(); end
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (act_busy(n) !== 1'b1) begin errors++; $display("FAIL middiv_busy_before inst%0d: got %0b want 1", n, act_busy(n)); end
    end
    reset = 1'b0;
    model_clear();
    #1;
    for (int n = 0; n < 2; n++) begin
      checks += 2;
      if (act_busy(n) !== 1'b0 || act_start(n) !== 1'b0) begin
        errors++; $display("FAIL middiv_async inst%0d: busy %0b start %0b want 0 0", n, act_busy(n), act_start(n));
      end
      if (act_stall(n) !== 1'b0) begin errors++; $display("FAIL middiv_stall_in_reset inst%0d: got %0b want 0", n, act_stall(n)); end
    end
    eval(); advance();
    reset = 1'b1;
    eval();
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (act_stall(n) !== 1'b0) begin errors++; $display("FAIL middiv_mf_issue inst%0d: stall %0b want 0", n, act_stall(n)); end
    end
    advance();
    $display("test_reset_mid_div done");
  endtask

  task automatic test_random();
    idle(12);
    for (int k = 0; k < 400; k++) begin
      int rmap[4] = '{0, 8, 9, 10};
      bit md = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 9) < 8, rmap[$urandom_range(0, 3)], rmap[$urandom_range(0, 3)],
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            rmap[$urandom_range(0, 3)], md, 1'($urandom), ($urandom_range(0, 9) == 0));
      eval();
      for (int n = 0; n < 2; n++) begin
        checks += 5;
        if (act_stall(n) !== e_stall[n]) begin
          errors++; $display("FAIL rand_stall inst%0d cyc%0d: got %0b want %0b", n, cyc, act_stall(n), e_stall[n]);
        end
        if (act_rs(n) !== e_rs[n]) begin
          errors++; $display("FAIL rand_fwd_rs inst%0d cyc%0d: got %0d want %0d", n, cyc, act_rs(n), e_rs[n]);
        end
        if (act_rt(n) !== e_rt[n]) begin
          errors++; $display("FAIL rand_fwd_rt inst%0d cyc%0d: got %0d want %0d", n, cyc, act_rt(n), e_rt[n]);
        end
        if (act_busy(n) !== e_busy[n]) begin
          errors++; $display("FAIL rand_busy inst%0d cyc%0d: got %0b want %0b", n, cyc, act_busy(n), e_busy[n]);
        end
        if (act_start(n) !== e_start[n]) begin
          errors++; $display("FAIL rand_start inst%0d cyc%0d: got %0b want %0b", n, cyc, act_start(n), e_start[n]);
        end
      end
      advance();
    end
    $display("test_random done: 400 cycles");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
    model_clear();
    test_reset();
    test_load_use();
    test_alu_chain();
    test_mdu(1'b1);
    test_mdu(1'b0);
    test_reset_mid_div();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
